// File: rtl/execs_muldiv_if.sv
// Multiply/divide unit handshake and result bus shared between the
// execute-stage control (master) and the iterative unit (slave).
interface execs_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             Md_start;
  logic [5:0]       Function_opcode;
  logic [WIDTH-1:0] Read_data_1;
  logic [WIDTH-1:0] Read_data_2;
  logic             Busy;
  logic             Done;
  logic             Div_zero;
  logic [WIDTH-1:0] Md_Result;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;

  modport master (
    output Md_start, Function_opcode, Read_data_1, Read_data_2,
    input  Busy, Done, Div_zero, Md_Result, Hi, Lo
  );

  modport slave (
    input  Md_start, Function_opcode, Read_data_1, Read_data_2,
    output Busy, Done, Div_zero, Md_Result, Hi, Lo
  );
endinterface

// File: rtl/execs_muldiv.sv
// Iterative multiply/divide unit owning the HI/LO pair.
// Multiply is unsigned shift-add on magnitudes, divide is restoring on
// magnitudes; both take one bit per cycle and signs are fixed up at the end.
module execs_muldiv #(
  parameter int WIDTH = 32
) (
  input logic             clock,
  input logic             reset,
  execs_muldiv_if.slave   bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  // acc_hi_q: running upper product / partial remainder
  // acc_lo_q: multiplier shifting out + product low bits / dividend shifting out + quotient bits
  logic [WIDTH-1:0] acc_hi_q, acc_lo_q;
  logic [WIDTH-1:0] opnd_q;          // multiplicand or divisor magnitude
  logic             is_div_q;
  logic             neg_lo_q;        // product / quotient needs negation
  logic             neg_hi_q;        // remainder takes the dividend's sign
  logic             dz_q;            // divisor was zero
  logic             busy_q, done_q, div_zero_q;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_shift, div_trial;
  logic [WIDTH-1:0] step_hi_d, step_lo_d;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] res_hi_d, res_lo_d;

  // Operand magnitudes and signs for the signed variants (funct bit 0 clear)
  always_comb begin
    a_neg = ~bus.Function_opcode[0] & bus.Read_data_1[WIDTH-1];
    b_neg = ~bus.Function_opcode[0] & bus.Read_data_2[WIDTH-1];
    a_mag = a_neg ? -bus.Read_data_1 : bus.Read_data_1;
    b_mag = b_neg ? -bus.Read_data_2 : bus.Read_data_2;
  end

  // One multiply or divide iteration
  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, opnd_q};
    step_hi_d = mul_sum[WIDTH:1];
    step_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    if (is_div_q) begin
      if (!div_trial[WIDTH]) begin
        step_hi_d = div_trial[WIDTH-1:0];
        step_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
      end else begin
        step_hi_d = div_shift[WIDTH-1:0];
        step_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Sign correction of the finished magnitudes, committed in FIX
  always_comb begin
    prod     = {acc_hi_q, acc_lo_q};
    prod_fix = neg_lo_q ? -prod : prod;
    if (is_div_q) begin
      res_lo_d = dz_q ? '1 : (neg_lo_q ? -acc_lo_q : acc_lo_q);
      res_hi_d = neg_hi_q ? -acc_hi_q : acc_hi_q;
    end else begin
      res_lo_d = prod_fix[WIDTH-1:0];
      res_hi_d = prod_fix[2*WIDTH-1:WIDTH];
    end
  end

  // Control FSM, datapath registers and HI/LO
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      opnd_q     <= '0;
      is_div_q   <= 1'b0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      dz_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.Md_start) begin
            case (bus.Function_opcode)
              F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                is_div_q <= bus.Function_opcode[1];
                neg_lo_q <= a_neg ^ b_neg;
                acc_hi_q <= '0;
                cnt_q    <= CW'(WIDTH - 1);
                busy_q   <= 1'b1;
                state_q  <= S_CALC;
                if (bus.Function_opcode[1]) begin
                  acc_lo_q <= a_mag;
                  opnd_q   <= b_mag;
                  neg_hi_q <= a_neg;
                  dz_q     <= (bus.Read_data_2 == '0);
                end else begin
                  acc_lo_q <= b_mag;
                  opnd_q   <= a_mag;
                  neg_hi_q <= 1'b0;
                  dz_q     <= 1'b0;
                end
              end
              F_MTHI:  hi_q <= bus.Read_data_1;
              F_MTLO:  lo_q <= bus.Read_data_1;
              default: ;
            endcase
          end
        end
        S_CALC: begin
          acc_hi_q <= step_hi_d;
          acc_lo_q <= step_lo_d;
          if (cnt_q == '0) state_q <= S_FIX;
          else             cnt_q   <= cnt_q - CW'(1);
        end
        S_FIX: begin
          hi_q       <= res_hi_d;
          lo_q       <= res_lo_d;
          done_q     <= 1'b1;
          div_zero_q <= is_div_q & dz_q;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;
  assign bus.Div_zero  = div_zero_q;
  assign bus.Hi        = hi_q;
  assign bus.Lo        = lo_q;
  assign bus.Md_Result = (bus.Function_opcode == F_MFHI) ? hi_q :
                         (bus.Function_opcode == F_MFLO) ? lo_q : '0;

endmodule

// File: tb/tb_execs_muldiv.sv
// Directed bench for execs_muldiv at WIDTH=32.
module tb_execs_muldiv;

  logic clock;
  logic reset;
  int   vectors;
  int   miscompares;
  int   n;
  int   dones;

  execs_muldiv_if #(.WIDTH(32)) bus ();

  execs_muldiv #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present a request for one edge, then withdraw it
  task automatic start_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    bus.Md_start        = 1'b1;
    bus.Function_opcode = f;
    bus.Read_data_1     = a;
    bus.Read_data_2     = b;
    tick();
    bus.Md_start = 1'b0;
  endtask

  // Edges from the start edge until Done is seen, bounded
  task automatic wait_done(output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!bus.Done && cnt < 200);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    bus.Md_start        = 1'b0;
    bus.Function_opcode = 6'h00;
    bus.Read_data_1     = '0;
    bus.Read_data_2     = '0;
    repeat (2) tick();

    check("reset_busy", {31'b0, bus.Busy}, 32'd0);
    check("reset_done", {31'b0, bus.Done}, 32'd0);
    check("reset_dz",   {31'b0, bus.Div_zero}, 32'd0);
    check("reset_hi",   bus.Hi, 32'h0);
    check("reset_lo",   bus.Lo, 32'h0);
    reset = 1'b1;
    tick();

    // MULT -1 * 3
    start_op(6'h18, 32'hFFFFFFFF, 32'h00000003);
    check("mult_busy", {31'b0, bus.Busy}, 32'd1);
    wait_done(n);
    check("mult_latency", n, 32'd33);
    check("mult_hi", bus.Hi, 32'hFFFFFFFF);
    check("mult_lo", bus.Lo, 32'hFFFFFFFD);
    check("mult_dz", {31'b0, bus.Div_zero}, 32'd0);
    bus.Function_opcode = 6'h10; #1;
    check("mfhi", bus.Md_Result, 32'hFFFFFFFF);
    bus.Function_opcode = 6'h12; #1;
    check("mflo", bus.Md_Result, 32'hFFFFFFFD);
    bus.Function_opcode = 6'h18; #1;
    check("mdres_other", bus.Md_Result, 32'h0);
    tick();
    check("done_clears", {31'b0, bus.Done}, 32'd0);

    // MULTU, then DIVU issued in the Done cycle
    start_op(6'h19, 32'hFFFFFFFF, 32'h00000003);
    wait_done(n);
    check("multu_latency", n, 32'd33);
    check("multu_hi", bus.Hi, 32'h00000002);
    check("multu_lo", bus.Lo, 32'hFFFFFFFD);
    start_op(6'h1B, 32'd100, 32'd7);
    check("b2b_busy", {31'b0, bus.Busy}, 32'd1);
    wait_done(n);
    check("divu_latency", n, 32'd33);
    check("divu_lo", bus.Lo, 32'h0000000E);
    check("divu_hi", bus.Hi, 32'h00000002);
    tick();

    // Signed divide -7 / 2
    start_op(6'h1A, 32'hFFFFFFF9, 32'h00000002);
    wait_done(n);
    check("div_latency", n, 32'd33);
    check("div_lo", bus.Lo, 32'hFFFFFFFD);
    check("div_hi", bus.Hi, 32'hFFFFFFFF);
    tick();

    // Signed overflow
    start_op(6'h1A, 32'h80000000, 32'hFFFFFFFF);
    wait_done(n);
    check("ovf_latency", n, 32'd33);
    check("ovf_lo", bus.Lo, 32'h80000000);
    check("ovf_hi", bus.Hi, 32'h00000000);
    check("ovf_dz", {31'b0, bus.Div_zero}, 32'd0);
    tick();

    // Divide by zero
    start_op(6'h1A, 32'h00000005, 32'h00000000);
    wait_done(n);
    check("dz_latency", n, 32'd33);
    check("dz_flag", {31'b0, bus.Div_zero}, 32'd1);
    check("dz_lo", bus.Lo, 32'hFFFFFFFF);
    check("dz_hi", bus.Hi, 32'h00000005);
    tick();
    check("dz_done_clr", {31'b0, bus.Done}, 32'd0);
    check("dz_flag_clr", {31'b0, bus.Div_zero}, 32'd0);

    // MTHI / MTLO while idle
    start_op(6'h11, 32'h12345678, 32'h0);
    check("mthi_hi", bus.Hi, 32'h12345678);
    check("mthi_busy", {31'b0, bus.Busy}, 32'd0);
    check("mthi_done", {31'b0, bus.Done}, 32'd0);
    start_op(6'h13, 32'h9ABCDEF0, 32'h0);
    check("mtlo_lo", bus.Lo, 32'h9ABCDEF0);
    check("mtlo_hi_kept", bus.Hi, 32'h12345678);

    // Requests while busy are ignored; no bypass of the in-flight result
    start_op(6'h19, 32'd2, 32'd3);
    dones = 0;
    repeat (4) tick();
    check("busy_high", {31'b0, bus.Busy}, 32'd1);
    bus.Function_opcode = 6'h12; #1;
    check("busy_old_lo", bus.Md_Result, 32'h9ABCDEF0);
    start_op(6'h18, 32'd5, 32'd5);
    start_op(6'h11, 32'hDEADBEEF, 32'h0);
    check("busy_mthi_ign", bus.Hi, 32'h12345678);
    repeat (60) begin
      tick();
      if (bus.Done) dones++;
    end
    check("busy_one_done", dones, 32'd1);
    check("busy_lo", bus.Lo, 32'd6);
    check("busy_hi", bus.Hi, 32'd0);

    // Asynchronous reset mid-operation
    start_op(6'h1B, 32'd1000, 32'd3);
    repeat (9) tick();
    #2 reset = 1'b0;
    #1;
    check("arst_busy", {31'b0, bus.Busy}, 32'd0);
    check("arst_hi", bus.Hi, 32'h0);
    check("arst_lo", bus.Lo, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    dones = 0;
    repeat (50) begin
      tick();
      if (bus.Done) dones++;
    end
    check("arst_no_done", dones, 32'd0);
    start_op(6'h19, 32'd6, 32'd7);
    wait_done(n);
    check("post_rst_latency", n, 32'd33);
    check("post_rst_lo", bus.Lo, 32'd42);
    check("post_rst_hi", bus.Hi, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
